// File: rtl/pipeline_step_controller_pkg.sv
// Shared codes and default widths for the
// pipeline run/step sequencer.
package pipeline_step_controller_pkg;

  localparam int CNT_WIDTH_DEF  = 32;
  localparam int STEP_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    CMD_CLEAR = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_STOP  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

endpackage

// File: rtl/pipeline_step_controller_cycle_counter.sv
// Saturating count of executed pipeline cycles,
// cleared only by an explicit clear pulse.
module cycle_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_inc,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_count
);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_inc && (o_count != '1)) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_step_controller.sv
// Run/step sequencer driving the shared pipeline
// register enable; freezes on a retired HALT.
module pipeline_step_controller
  import pipeline_step_controller_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int STEP_WIDTH = STEP_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  input  logic [STEP_WIDTH-1:0] i_cmd_arg,
  output logic                  o_cmd_ready,
  input  logic                  i_halt_wb,
  output logic                  o_pipe_enable,
  output logic                  o_done,
  output logic                  o_halted,
  output logic [1:0]            o_state,
  output logic [CNT_WIDTH-1:0]  o_cycle_count
);

  localparam logic [STEP_WIDTH-1:0] ONE =
    {{(STEP_WIDTH-1){1'b0}}, 1'b1};

  state_e                state;
  logic [STEP_WIDTH-1:0] remaining;
  logic                  done_q;
  logic                  accept;
  logic                  halt_hit;
  logic                  cnt_clear;
  cmd_e                  cmd;

  assign cmd      = cmd_e'(i_cmd);
  assign accept   = i_cmd_valid && o_cmd_ready;
  assign halt_hit = o_pipe_enable && i_halt_wb;

  // Outputs decode from registered state only.
  assign o_pipe_enable = (state == ST_RUN) ||
                         (state == ST_STEP);
  assign o_cmd_ready   = (state != ST_STEP);
  assign o_halted      = (state == ST_HALTED);
  assign o_state       = state;
  assign o_done        = done_q;

  assign cnt_clear = accept && (cmd == CMD_CLEAR) &&
                     ((state == ST_IDLE) ||
                      (state == ST_HALTED));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (halt_hit) begin
        state     <= ST_HALTED;
        remaining <= '0;
        done_q    <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (accept) begin
              unique case (1'b1)
                (cmd == CMD_RUN): state <= ST_RUN;
                (cmd == CMD_STEP): begin
                  state     <= ST_STEP;
                  remaining <= (i_cmd_arg == '0) ?
                               ONE : i_cmd_arg;
                end
                (cmd == CMD_CLEAR),
                (cmd == CMD_STOP): state <= ST_IDLE;
              endcase
            end
          end
          ST_RUN: begin
            if (accept && (cmd == CMD_STOP))
              state <= ST_IDLE;
          end
          ST_STEP: begin
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
          ST_HALTED: begin
            if (accept && (cmd == CMD_CLEAR))
              state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  cycle_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_inc  (o_pipe_enable),
    .i_clear(cnt_clear),
    .o_count(o_cycle_count)
  );

endmodule

// File: doc/pipeline_step_controller.md
# pipeline_step_controller

Run/step sequencer for the pipelined MIPS datapath; the decode-stage sign extender and every other stage advance only when this block asserts the shared pipeline-register enable. It accepts RUN/STEP/STOP/CLEAR commands from the debug unit over a valid/ready handshake. It freezes the pipeline on a retired HALT and counts executed cycles for the debug read-back.

## Interface
- CNT_WIDTH, 32, width of the executed-cycle counter
- STEP_WIDTH, 16, width of the step-count argument
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command present
- i_cmd  in  2  00 CLEAR, 01 RUN, 10 STEP, 11 STOP
- i_cmd_arg  in  STEP_WIDTH  cycles to advance for STEP (0 treated as 1); ignored otherwise
- o_cmd_ready  out  1  block can accept a command
- i_halt_wb  in  1  HALT instruction in WB stage this cycle
- o_pipe_enable  out  1  pipeline register / PC enable, registered
- o_done  out  1  one-cycle pulse: STEP finished or HALT reached
- o_halted  out  1  high while in HALTED
- o_state  out  2  current state encoding, for debug
- o_cycle_count  out  CNT_WIDTH  cycles with o_pipe_enable=1, saturating

## Operation
- Command accepted on a rising edge where i_cmd_valid && o_cmd_ready.
- States: IDLE=00, RUN=01, STEP=10, HALTED=11.
- IDLE: enable 0, ready 1.
  - RUN -> RUN.
  - STEP -> STEP with remaining = max(i_cmd_arg,1).
  - CLEAR -> counter 0, stay IDLE.
  - STOP -> accepted, no effect, no o_done.
- RUN: enable 1, ready 1.
  - STOP -> IDLE.
  - RUN/STEP/CLEAR accepted and ignored.
- STEP: enable 1, ready 0; remaining decrements each enabled cycle.
  - At remaining==1 -> IDLE with o_done.
- HALTED: enable 0, ready 1.
  - CLEAR -> IDLE, counter 0.
  - Other commands accepted and ignored.
- HALT detection: i_halt_wb sampled only in a cycle with o_pipe_enable=1.
  - From RUN or STEP -> HALTED, o_done pulse. Halt has priority over STOP and over STEP completion in the same cycle.
- Counter:
  - +1 at every edge closing a cycle with o_pipe_enable=1.
  - Holds at all-ones; no wrap.
  - CLEAR is the only software clear.

## Timing
- Reset (async, immediate): state IDLE, o_pipe_enable 0, o_done 0, o_halted 0, o_cmd_ready 1, o_cycle_count 0, remaining 0. Reset mid-RUN/STEP drops enable in the same cycle without waiting for an edge.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- Command accepted at edge t: o_pipe_enable high from cycle t+1.
- STEP N: enable high for exactly cycles t+1..t+N. State IDLE and o_done=1 in cycle t+N+1; o_done low at t+N+2.
- STOP accepted at edge t in RUN: enable low from cycle t+1.
- Halt seen in cycle c: enable low, o_halted=1 and o_done=1 in cycle c+1. Count includes cycle c.
- o_cmd_ready returns high in the cycle o_done pulses after STEP.

## Structure
- Shared package holds:
  - command codes CMD_CLEAR/RUN/STEP/STOP
  - state encodings ST_IDLE/RUN/STEP/HALTED
  - default widths
- One sub-module `cycle_counter` (CNT_WIDTH param, inputs i_clk/i_reset/i_inc/i_clear, saturating).
- The FSM, step down-counter and output registers live in the top.

## Test plan
- Reset mid-RUN with counter at 37 -> same cycle enable 0, state 00, count 0, ready 1.
- STEP arg=3 at edge t -> enable high exactly 3 cycles, o_done single pulse at t+4, count +3, ready 0 during t+1..t+3.
- STEP arg=0 -> behaves as 1: one enable cycle, o_done at t+2.
- RUN, then STOP after 10 enabled cycles -> enable low next cycle, count 10, no o_done; then CLEAR -> count 0.
- RUN with i_halt_wb=1 on 5th enabled cycle, STOP presented same cycle -> HALTED, o_done pulse, o_halted 1, count 5. RUN ignored while halted; CLEAR -> IDLE, count 0.
- Force counter near all-ones (CNT_WIDTH=4), RUN 20 cycles -> o_cycle_count sticks at 15.
